// File: rtl/edge_bridge_pkg.sv
// edge_bridge_pkg: state encoding and lane-geometry helpers shared by the edge stream bridge.
package edge_bridge_pkg;

    typedef enum logic [1:0] {LOAD, FIRE, WAIT, DRAIN} state_e;

    function automatic int lane_count(input int array_dim, input int tile_dim);
        return 4 * array_dim * tile_dim;
    endfunction

    function automatic int lane_cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int LANE_CNT_W = lane_cnt_w(lane_count(2, 2));

endpackage

// File: rtl/edge_lane_sel.sv
// edge_lane_sel: W-bit lane write-demux (pack path) and read-mux (unpack path), both indexed by k.
module edge_lane_sel
    import edge_bridge_pkg::*;
#(
    parameter int W  = 32,
    parameter int N  = 16,
    parameter int KW = 4
) (
    input  logic [KW-1:0]  k,
    input  logic           wr_en,
    input  logic [W-1:0]   wr_data,
    input  logic [0:N*W-1] wr_vec,
    output logic [0:N*W-1] wr_vec_nxt,
    input  logic [0:N*W-1] rd_vec,
    output logic [W-1:0]   rd_data
);

    for (genvar g = 0; g < N; g++) begin : g_lane
        assign wr_vec_nxt[g*W +: W] = (wr_en && k == KW'(g)) ? wr_data : wr_vec[g*W +: W];
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < N; i++)
            rd_data = (k == KW'(i)) ? rd_vec[i*W +: W] : rd_data;
    end

endmodule

// File: rtl/edge_stream_bridge.sv
// edge_stream_bridge: packs host words into the array edge input, fires the array, and streams the captured edge output back.
// EDGE_TIMEOUT_EN adds a WAIT watchdog that drains zeros and raises a sticky timeout_err.
module edge_stream_bridge
    import edge_bridge_pkg::*;
#(
    parameter  int MAX_WORD_LENGTH = 32,
    parameter  int ARRAY_DIM       = 2,
    parameter  int TILE_DIM        = 2,
    parameter  int TIMEOUT_CYCLES  = 1024,
    localparam int W               = MAX_WORD_LENGTH,
    localparam int N               = lane_count(ARRAY_DIM, TILE_DIM)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           s_valid,
    output logic           s_ready,
    input  logic [W-1:0]   s_data,
    output logic [0:N*W-1] edge_i,
    output logic           edge_start,
    input  logic           edge_finish,
    input  logic [0:N*W-1] edge_o,
    output logic           m_valid,
    input  logic           m_ready,
    output logic [W-1:0]   m_data,
    output logic           busy,
    output logic           timeout_err
);

    localparam int KW = lane_cnt_w(N);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_e         state_q, state_d;
    logic [KW-1:0]  k_q, k_d;
    logic [0:N*W-1] edge_q, edge_d, cap_q, cap_d;
    logic           s_ready_q, s_ready_d;
    logic           wr_en, last;
    logic [W-1:0]   rd_data;

`ifdef EDGE_TIMEOUT_EN
    localparam int TW = lane_cnt_w(TIMEOUT_CYCLES);
    logic [TW-1:0] tmo_q, tmo_d;
    logic          tmo_err_q, tmo_err_d;
`endif

    // k is shared by the pack and unpack paths since LOAD and DRAIN never overlap
    edge_lane_sel #(.W(W), .N(N), .KW(KW)) u_lane_sel (
        .k         (k_q),
        .wr_en     (wr_en),
        .wr_data   (s_data),
        .wr_vec    (edge_q),
        .wr_vec_nxt(edge_d),
        .rd_vec    (cap_q),
        .rd_data   (rd_data)
    );

    assign last = k_q == KW'(N - 1);

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        cap_d   = cap_q;
        wr_en   = 1'b0;
`ifdef EDGE_TIMEOUT_EN
        tmo_d     = tmo_q;
        tmo_err_d = tmo_err_q;
`endif
        case (state_q)
            LOAD: if (s_valid && s_ready_q) begin
                wr_en   = 1'b1;
                k_d     = last ? '0 : k_q + 1'b1;
                state_d = last ? FIRE : LOAD;
            end
            FIRE: begin
                state_d = WAIT;
`ifdef EDGE_TIMEOUT_EN
                tmo_d = '0;
`endif
            end
            WAIT: if (edge_finish) begin
                cap_d   = edge_o;
                state_d = DRAIN;
            end
`ifdef EDGE_TIMEOUT_EN
            else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                tmo_err_d = 1'b1;
                cap_d     = '0;
                state_d   = DRAIN;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
`endif
            DRAIN: if (m_ready) begin
                k_d     = last ? '0 : k_q + 1'b1;
                state_d = last ? LOAD : DRAIN;
            end
            default: state_d = LOAD;
        endcase
        s_ready_d = state_d == LOAD;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= LOAD;
            k_q       <= '0;
            edge_q    <= '0;
            cap_q     <= '0;
            s_ready_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            edge_q    <= edge_d;
            cap_q     <= cap_d;
            s_ready_q <= s_ready_d;
        end
    end

`ifdef EDGE_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_q     <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            tmo_q     <= tmo_d;
            tmo_err_q <= tmo_err_d;
        end
    end

    assign timeout_err = tmo_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign s_ready    = s_ready_q;
    assign edge_i     = edge_q;
    assign edge_start = state_q == FIRE;
    assign m_valid    = state_q == DRAIN;
    assign m_data     = m_valid ? rd_data : '0;
    assign busy       = !(state_q == LOAD && k_q == '0);

endmodule

// File: tb/tb_edge_stream_bridge.sv
// tb_edge_stream_bridge: directed sequence with randomized words checked against a word-array model of the edge.
module tb_edge_stream_bridge;
    import edge_bridge_pkg::*;

    localparam int W  = 32;
    localparam int N  = 1 << LANE_CNT_W;
    localparam int EW = N * W;

    logic          clk = 1'b0;
    logic          reset, s_valid, s_ready, edge_start, edge_finish;
    logic          m_valid, m_ready, busy, timeout_err;
    logic [W-1:0]  s_data, m_data;
    logic [0:EW-1] edge_i, edge_o, exp_edge;
    logic [W-1:0]  in_words  [N];
    logic [W-1:0]  out_words [N];
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    edge_stream_bridge #(.MAX_WORD_LENGTH(W), .ARRAY_DIM(2), .TILE_DIM(2), .TIMEOUT_CYCLES(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .edge_i     (edge_i),
        .edge_start (edge_start),
        .edge_finish(edge_finish),
        .edge_o     (edge_o),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    function automatic logic [0:EW-1] pack(input logic [W-1:0] w [N]);
        logic [0:EW-1] r;
        for (int i = 0; i < N; i++) r[i*W +: W] = w[i];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [W-1:0] d);
        int n = 0;
        s_valid = 1'b1;
        s_data  = d;
        while (s_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", s_ready, 1);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic load(input int start, input bit gaps);
        for (int i = start; i < N; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
            send(in_words[i]);
        end
        exp_edge = pack(in_words);
    endtask

    task automatic drain(input int mode);
        int idx = 0;
        int n = 0;
        while (idx < N && n < 200) begin
            if (mode == 0) m_ready = 1'b1;
            else if (mode == 1) m_ready = (n % 4 == 0) || (n % 4 == 3);
            else m_ready = 1'($urandom_range(0, 1));
            chk("drain_valid", m_valid, 1);
            chk("drain_data", m_data, out_words[idx]);
            @(negedge clk);
            if (m_ready) idx++;
            n++;
        end
        m_ready = 1'b0;
        chk("drain_end_valid", m_valid, 0);
        chk("drain_end_s_ready", s_ready, 1);
        chk("drain_end_busy", busy, 0);
    endtask

    task automatic rand_words(output logic [W-1:0] w [N]);
        for (int i = 0; i < N; i++) w[i] = $urandom;
    endtask

    initial begin
        reset = 1'b0; s_valid = 1'b0; s_data = '0; edge_finish = 1'b0; edge_o = '0; m_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_edge_i", edge_i, 0);
        chk("rst_edge_start", edge_start, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_timeout", timeout_err, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_s_ready", s_ready, 1);

        // basic load with incrementing words, then stray s_valid/edge_finish outside their states
        for (int i = 0; i < N; i++) in_words[i] = W'(i);
        load(0, 1'b0);
        chk("fire_start", edge_start, 1);
        chk("fire_s_ready", s_ready, 0);
        chk("fire_edge_i", edge_i, exp_edge);
        chk("lane0", edge_i[0:W-1], 32'h0);
        chk("lane15", edge_i[EW-W:EW-1], 32'hF);
        s_valid = 1'b1; s_data = 32'hDEAD_BEEF;
        edge_finish = 1'b1; edge_o = {N{32'hBAD0_0BAD}};
        @(negedge clk);
        chk("no_fire_capture", m_valid, 0);
        edge_finish = 1'b0;
        repeat (3) begin
            chk("start_one_cycle", edge_start, 0);
            @(negedge clk);
        end
        chk("wait_busy", busy, 1);
        chk("wait_no_valid", m_valid, 0);
        chk("wait_s_ready", s_ready, 0);
        chk("wait_edge_i_held", edge_i, exp_edge);
        for (int i = 0; i < N; i++) out_words[i] = 32'hA500_0000 + W'(i);
        edge_o = pack(out_words); edge_finish = 1'b1; s_valid = 1'b0;
        @(negedge clk);
        chk("finish_latency", m_valid, 1);
        edge_finish = 1'b0; edge_o = {N{32'h5A5A_5A5A}};
        drain(0);
        chk("edge_i_kept", edge_i, exp_edge);

        // single-lane overwrite, finish high at WAIT entry and held, 1-0-0-1 backpressure
        rand_words(in_words);
        send(in_words[0]);
        chk("lane0_new", edge_i[0:W-1], in_words[0]);
        chk("lanes_kept", edge_i[W:EW-1], exp_edge[W:EW-1]);
        chk("partial_busy", busy, 1);
        load(1, 1'b1);
        chk("fire2_edge_i", edge_i, exp_edge);
        edge_finish = 1'b1; edge_o = {N{32'h1111_2222}};
        @(negedge clk);
        chk("held_no_early", m_valid, 0);
        rand_words(out_words);
        edge_o = pack(out_words);
        @(negedge clk);
        chk("held_capture", m_valid, 1);
        edge_o = {N{32'h7777_8888}};
        drain(1);
        edge_finish = 1'b0;

        // asynchronous reset mid-load discards the partial load
        rand_words(in_words);
        for (int i = 0; i < 7; i++) send(in_words[i]);
        reset = 1'b0;
        #1;
        chk("mid_rst_edge_i", edge_i, 0);
        chk("mid_rst_s_ready", s_ready, 0);
        chk("mid_rst_busy", busy, 0);
        @(negedge clk);
        reset = 1'b1;
        rand_words(in_words);
        load(0, 1'b1);
        chk("reload_edge_i", edge_i, exp_edge);
        rand_words(out_words);
        repeat (2) @(negedge clk);
        edge_o = pack(out_words); edge_finish = 1'b1;
        @(negedge clk);
        chk("reload_finish", m_valid, 1);
        edge_finish = 1'b0;
        drain(2);

        // no finish at all: watchdog drains zeros, or WAIT holds indefinitely
        rand_words(in_words);
        load(0, 1'b1);
        edge_o = {N{32'hCAFE_F00D}};
`ifdef EDGE_TIMEOUT_EN
        repeat (8) @(negedge clk);
        chk("pre_timeout_valid", m_valid, 0);
        chk("pre_timeout_err", timeout_err, 0);
        @(negedge clk);
        chk("timeout_err", timeout_err, 1);
        chk("timeout_valid", m_valid, 1);
        for (int i = 0; i < N; i++) out_words[i] = '0;
        drain(2);
        chk("timeout_sticky", timeout_err, 1);
`else
        repeat (40) @(negedge clk);
        chk("no_timeout_valid", m_valid, 0);
        chk("no_timeout_busy", busy, 1);
        chk("no_timeout_err", timeout_err, 0);
        rand_words(out_words);
        edge_o = pack(out_words); edge_finish = 1'b1;
        @(negedge clk);
        chk("late_finish", m_valid, 1);
        edge_finish = 1'b0;
        drain(0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/edge_stream_bridge.md
Name: edge_stream_bridge

Overview:
- Host-side counterpart of one array edge I/O port of the bit-serial tile array.
- Accepts a stream of MAX_WORD_LENGTH-bit words over valid/ready and packs them into the wide parallel edge-input vector.
- Pulses the array start, waits for the edge finish, captures the wide edge-output vector, and streams it back to the host word by word.
- One instance per edge (E/W/N/S); it sits between the host interconnect and the array top level.

Parameters:
- MAX_WORD_LENGTH, 32, bits per lane word (W).
- ARRAY_DIM, 2, tiles per array row/column.
- TILE_DIM, 2, PEs per tile row/column.
- TIMEOUT_CYCLES, 1024, watchdog limit in WAIT; used only with EDGE_TIMEOUT_EN.
- Derived: N = 4*ARRAY_DIM*TILE_DIM lanes (16 at defaults); edge width = N*W (512 at defaults).

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low (0 = reset asserted).
- s_valid  in  1  host word valid.
- s_ready  out  1  bridge accepts word.
- s_data  in  W  host word.
- edge_i  out  [0:N*W-1]  packed vector driven to the array edge input.
- edge_start  out  1  one-cycle start pulse to the array.
- edge_finish  in  1  array edge-converter finish flag (level or pulse).
- edge_o  in  [0:N*W-1]  array edge output vector.
- m_valid  out  1  result word valid.
- m_ready  in  1  host accepts result word.
- m_data  out  W  result word.
- busy  out  1  high in every state except LOAD with lane count 0.
- timeout_err  out  1  sticky watchdog error; constant 0 when the feature is compiled out.

Behaviour:
- Reset values (asynchronous, while reset=0): state=LOAD, lane count=0, edge_i=0, capture register=0, edge_start=0, s_ready=0, m_valid=0, m_data=0, busy=0, timeout_err=0.
- After reset deasserts, s_ready goes to 1 on the first clock.
- States: LOAD, FIRE, WAIT, DRAIN.
- LOAD:
  - s_ready=1.
  - Each handshake (s_valid&&s_ready) writes s_data to edge_i[k*W +: W], where k is the lane count; lane 0 is the leftmost (index 0) word.
  - k increments on each handshake.
  - On the handshake with k==N-1: k returns to 0, s_ready drops the next cycle, and the state moves to FIRE.
- FIRE:
  - edge_start=1 for exactly one cycle; s_ready=0.
  - Next state is WAIT.
  - edge_finish is ignored in FIRE.
- WAIT:
  - edge_i is held stable.
  - On the first cycle edge_finish==1: capture edge_o into the capture register and move to DRAIN.
- DRAIN:
  - m_valid=1 from the first DRAIN cycle; m_data = capture[k*W +: W].
  - Each m_valid&&m_ready handshake increments k.
  - m_data and m_valid are held while m_ready=0.
  - After the handshake with k==N-1: m_valid=0 and the state returns to LOAD.
  - s_ready rises in the same cycle DRAIN exits; there is no LOAD/DRAIN overlap.
- Latency:
  - Last input word accepted at cycle t → edge_start high at t+1.
  - edge_finish sampled at t_f → m_valid high at t_f+1.
- Boundaries:
  - s_valid while not in LOAD: ignored, since s_ready=0.
  - edge_finish held high across multiple cycles: captured once only.
  - edge_finish already high when WAIT is entered: captured on the first WAIT cycle.
  - edge_i keeps its last values after DRAIN until individual lanes are overwritten in the next LOAD.
  - Reset mid-operation: everything returns to reset values immediately; a partial load is discarded.

Optional Feature:
- Macro EDGE_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in WAIT.
  - If it reaches TIMEOUT_CYCLES without edge_finish: timeout_err is set (sticky until reset), the capture register is loaded with zeros, and the state goes to DRAIN.
  - N zero words are streamed out.
  - The counter clears on WAIT entry.
- Undefined: no counter; WAIT is unbounded; timeout_err is tied to 0.

Decomposition:
- Shared package edge_bridge_pkg holds:
  - state enum (LOAD, FIRE, WAIT, DRAIN);
  - lane-count width constant $clog2(N);
  - function computing N from ARRAY_DIM and TILE_DIM.
- One natural sub-module: edge_lane_sel, a parameterised W-bit lane write-demux/read-mux indexed by k, reused for the pack and unpack paths.

Test Plan:
- Basic load and fire: feed words 0x00000000..0x0000000F with s_valid held at 1 → edge_i[0:31]=0x0, edge_i[480:511]=0xF; edge_start pulses exactly one cycle after the 16th handshake.
- Finish and drain: drive edge_o with lane k = 0xA5000000+k and pulse edge_finish at 5 cycles after edge_start → m_valid rises the next cycle; 16 words 0xA5000000..0xA500000F come out in order; s_ready=1 after the last one.
- Backpressure: drive m_ready with a 1-0-0-1 pattern during DRAIN → m_data is stable while stalled; there are no duplicate or missing words.
- Stray events: s_valid=1 in WAIT and edge_finish=1 in FIRE → no word is accepted and there is no premature capture; the capture occurs on the later WAIT finish.
- Mid-load reset: assert reset=0 after 7 words, release, then load 16 new words → edge_i contains only the new words and the lane count restarts at 0.
- Timeout (EDGE_TIMEOUT_EN, TIMEOUT_CYCLES=8): never assert edge_finish → timeout_err=1 after 8 WAIT cycles and 16 zero words are drained; rebuild without the macro → the bridge stays in WAIT and timeout_err=0.
